// File: rtl/mem_rqst_issue.sv
// mem_rqst_issue: request issue stage in front of memory_controller.
// Buffers core read/write requests in a DEPTH-entry FIFO, issues them as
// single-cycle wr_en/rd_en pulses under a MAX_OUT outstanding-credit limit,
// and forwards controller acks back to the core as one-cycle responses.
// Optional feature macro: MEM_RQST_HAZARD_EN (read-after-write address
// stall against a table of issued, unacked writes).
module mem_rqst_issue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [15:0] in_addr,
    input  logic [15:0] in_data,
    output logic [15:0] wr_address,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic [15:0] rd_address,
    output logic        rd_en,
    input  logic [15:0] wr_ret_address,
    input  logic        wr_ret_ack,
    input  logic [15:0] rd_ret_address,
    input  logic [15:0] rd_ret_data,
    input  logic        rd_ret_ack,
    output logic        resp_wr_valid,
    output logic [15:0] resp_wr_addr,
    output logic        resp_rd_valid,
    output logic [15:0] resp_rd_addr,
    output logic [15:0] resp_rd_data,
    output logic [3:0]  out_cnt,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    // FIFO storage and pointers
    logic [DEPTH-1:0]        we_mem;
    logic [DEPTH-1:0][15:0]  addr_mem, data_mem;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             fcnt_q;

    logic        push, issue, haz_stall, under;
    logic        head_we;
    logic [15:0] head_addr, head_data;
    logic [4:0]  cnt_eff;
    logic [3:0]  out_cnt_d;
    logic        err_d;

    logic        wr_en_q, rd_en_q, resp_wr_valid_q, resp_rd_valid_q, err_q;
    logic [15:0] wr_address_q, wr_data_q, rd_address_q;
    logic [15:0] resp_wr_addr_q, resp_rd_addr_q, resp_rd_data_q;
    logic [3:0]  out_cnt_q;

    assign in_ready  = (fcnt_q != (AW+1)'(DEPTH));
    assign push      = in_valid & in_ready;
    assign head_we   = we_mem[rptr_q];
    assign head_addr = addr_mem[rptr_q];
    assign head_data = data_mem[rptr_q];
    assign issue     = (fcnt_q != '0) & (out_cnt_q < 4'(MAX_OUT)) & ~haz_stall;

`ifdef MEM_RQST_HAZARD_EN
    logic [MAX_OUT-1:0]       tv_q, clr, alloc;
    logic [MAX_OUT-1:0][15:0] ta_q;
    logic                     wr_issue, found_c, found_a;

    // A write heading out is never stalled, so allocation can ignore haz_stall
    assign wr_issue = (fcnt_q != '0) & (out_cnt_q < 4'(MAX_OUT)) & head_we;

    // Head read stalls while any unacked write targets the same address
    always_comb begin
        haz_stall = 1'b0;
        for (int i = 0; i < MAX_OUT; i++)
            if (tv_q[i] && ta_q[i] == head_addr && !head_we) haz_stall = 1'b1;
    end

    // Ack clears lowest matching entry; new write takes lowest free entry
    always_comb begin
        clr     = '0;
        alloc   = '0;
        found_c = 1'b0;
        found_a = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (!found_c && wr_ret_ack && tv_q[i] && ta_q[i] == wr_ret_address) begin
                clr[i]  = 1'b1;
                found_c = 1'b1;
            end
            if (!found_a && wr_issue && !tv_q[i]) begin
                alloc[i] = 1'b1;
                found_a  = 1'b1;
            end
        end
    end

    // Hazard table state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q <= '0;
            ta_q <= '0;
        end else begin
            tv_q <= (tv_q & ~clr) | alloc;
            for (int i = 0; i < MAX_OUT; i++)
                if (alloc[i]) ta_q[i] <= head_addr;
        end
    end
`else
    assign haz_stall = 1'b0;
`endif

    // Outstanding count: acks that would drive the count negative are dropped
    always_comb begin
        cnt_eff = {1'b0, out_cnt_q} + {4'd0, issue};
        under   = 1'b0;
        if (wr_ret_ack) begin
            if (cnt_eff != '0) cnt_eff = cnt_eff - 5'd1;
            else               under   = 1'b1;
        end
        if (rd_ret_ack) begin
            if (cnt_eff != '0) cnt_eff = cnt_eff - 5'd1;
            else               under   = 1'b1;
        end
        out_cnt_d = cnt_eff[3:0];
        err_d     = err_q | under;
    end

    // FIFO payload write; entries beyond the pointers are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) begin
            we_mem[wptr_q]   <= in_we;
            addr_mem[wptr_q] <= in_addr;
            data_mem[wptr_q] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (push)  wptr_q <= wptr_q + 1'b1;
            if (issue) rptr_q <= rptr_q + 1'b1;
            fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(issue);
        end
    end

    // Issue, credit and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q         <= 1'b0;
            rd_en_q         <= 1'b0;
            wr_address_q    <= '0;
            wr_data_q       <= '0;
            rd_address_q    <= '0;
            out_cnt_q       <= '0;
            err_q           <= 1'b0;
            resp_wr_valid_q <= 1'b0;
            resp_wr_addr_q  <= '0;
            resp_rd_valid_q <= 1'b0;
            resp_rd_addr_q  <= '0;
            resp_rd_data_q  <= '0;
        end else begin
            wr_en_q <= issue & head_we;
            rd_en_q <= issue & ~head_we;
            if (issue && head_we) begin
                wr_address_q <= head_addr;
                wr_data_q    <= head_data;
            end
            if (issue && !head_we) rd_address_q <= head_addr;
            out_cnt_q       <= out_cnt_d;
            err_q           <= err_d;
            resp_wr_valid_q <= wr_ret_ack;
            if (wr_ret_ack) resp_wr_addr_q <= wr_ret_address;
            resp_rd_valid_q <= rd_ret_ack;
            if (rd_ret_ack) begin
                resp_rd_addr_q <= rd_ret_address;
                resp_rd_data_q <= rd_ret_data;
            end
        end
    end

    assign wr_en         = wr_en_q;
    assign rd_en         = rd_en_q;
    assign wr_address    = wr_address_q;
    assign wr_data       = wr_data_q;
    assign rd_address    = rd_address_q;
    assign out_cnt       = out_cnt_q;
    assign err           = err_q;
    assign resp_wr_valid = resp_wr_valid_q;
    assign resp_wr_addr  = resp_wr_addr_q;
    assign resp_rd_valid = resp_rd_valid_q;
    assign resp_rd_addr  = resp_rd_addr_q;
    assign resp_rd_data  = resp_rd_data_q;
endmodule

// File: tb/tb_mem_rqst_issue.sv
// Scoreboard bench for mem_rqst_issue: the driver runs a queue-based model
// of the request stream and pushes expected issues/responses (with the cycle
// they must appear); an independent monitor pops and compares.
module tb_mem_rqst_issue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_we = 1'b0;
    logic [15:0] in_addr = '0, in_data = '0;
    logic [15:0] wr_address, wr_data, rd_address;
    logic        wr_en, rd_en;
    logic [15:0] wr_ret_address = '0, rd_ret_address = '0, rd_ret_data = '0;
    logic        wr_ret_ack = 1'b0, rd_ret_ack = 1'b0;
    logic        resp_wr_valid, resp_rd_valid;
    logic [15:0] resp_wr_addr, resp_rd_addr, resp_rd_data;
    logic [3:0]  out_cnt;
    logic        err;

    mem_rqst_issue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_addr(in_addr), .in_data(in_data),
        .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en),
        .rd_address(rd_address), .rd_en(rd_en),
        .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
        .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data), .rd_ret_ack(rd_ret_ack),
        .resp_wr_valid(resp_wr_valid), .resp_wr_addr(resp_wr_addr),
        .resp_rd_valid(resp_rd_valid), .resp_rd_addr(resp_rd_addr), .resp_rd_data(resp_rd_data),
        .out_cnt(out_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        int          stamp;
    } item_t;

    item_t       mq[$], exp_iss[$], exp_wr[$], exp_rd[$];
    logic [15:0] out_wr[$], out_rd[$], wtab[$];
    int          exp_cnt = 0;
    logic        exp_err = 1'b0, exp_rdy = 1'b1;
    logic [15:0] last_wa = '0, last_wd = '0, last_ra = '0;
    int          cyc = 0, nvec = 0, nerr = 0, rd_pulses = 0;
    logic        acc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: sample #1 after each rising edge
    initial forever begin
        item_t it;
        @(posedge clk);
        cyc++;
        #1;
        chk("one_hot_en", {31'd0, wr_en & rd_en}, 0);
        if (rd_en) rd_pulses++;
        if (wr_en || rd_en) begin
            if (exp_iss.size() == 0) chk("unexpected_issue", {31'd0, wr_en | rd_en}, 0);
            else begin
                it = exp_iss.pop_front();
                chk("iss_kind", {31'd0, wr_en}, {31'd0, it.we});
                chk("iss_addr", wr_en ? wr_address : rd_address, it.addr);
                if (it.we) chk("iss_data", wr_data, it.data);
                chk("iss_cycle", cyc, it.stamp);
                if (it.we) begin last_wa = it.addr; last_wd = it.data; end
                else last_ra = it.addr;
            end
        end
        while (exp_iss.size() > 0 && exp_iss[0].stamp <= cyc) begin
            chk("missed_issue", {31'd0, wr_en | rd_en}, 1);
            void'(exp_iss.pop_front());
        end
        if (!wr_en) chk("wr_hold", {wr_address, wr_data}, {last_wa, last_wd});
        if (!rd_en) chk("rd_hold", rd_address, last_ra);
        if (resp_wr_valid) begin
            if (exp_wr.size() == 0) chk("unexpected_wresp", {31'd0, resp_wr_valid}, 0);
            else begin
                it = exp_wr.pop_front();
                chk("wresp_addr", resp_wr_addr, it.addr);
                chk("wresp_cycle", cyc, it.stamp);
            end
        end
        while (exp_wr.size() > 0 && exp_wr[0].stamp <= cyc) begin
            chk("missed_wresp", {31'd0, resp_wr_valid}, 1);
            void'(exp_wr.pop_front());
        end
        if (resp_rd_valid) begin
            if (exp_rd.size() == 0) chk("unexpected_rresp", {31'd0, resp_rd_valid}, 0);
            else begin
                it = exp_rd.pop_front();
                chk("rresp_addr", resp_rd_addr, it.addr);
                chk("rresp_data", resp_rd_data, it.data);
                chk("rresp_cycle", cyc, it.stamp);
            end
        end
        while (exp_rd.size() > 0 && exp_rd[0].stamp <= cyc) begin
            chk("missed_rresp", {31'd0, resp_rd_valid}, 1);
            void'(exp_rd.pop_front());
        end
        chk("out_cnt", out_cnt, exp_cnt);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    end

    // One cycle of stimulus plus the reference model for the coming edge
    task automatic step(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic wa, input logic ra, input logic [15:0] rdat, output logic accepted);
        logic        iss, wfull;
        logic [15:0] waddr, raddr;
        int          c;
        item_t       it;
        @(negedge clk);
        waddr = 16'h0077;
        raddr = 16'h0077;
        if (wa && out_wr.size() > 0) waddr = out_wr.pop_front();
        if (ra && out_rd.size() > 0) raddr = out_rd.pop_front();
        in_valid = v; in_we = we; in_addr = a; in_data = d;
        wr_ret_ack = wa; wr_ret_address = waddr;
        rd_ret_ack = ra; rd_ret_address = raddr; rd_ret_data = rdat;
        accepted = v && (mq.size() != DEPTH);
        iss = (mq.size() > 0) && (exp_cnt < MAX_OUT);
`ifdef MEM_RQST_HAZARD_EN
        if (iss && !mq[0].we)
            foreach (wtab[i]) if (wtab[i] == mq[0].addr) iss = 1'b0;
        wfull = (wtab.size() >= MAX_OUT);
        if (wa)
            for (int i = 0; i < wtab.size(); i++)
                if (wtab[i] == waddr) begin wtab.delete(i); break; end
        if (iss && mq[0].we && !wfull) wtab.push_back(mq[0].addr);
`else
        wfull = 1'b0;
`endif
        c = exp_cnt + int'(iss);
        if (wa) begin
            if (c > 0) c--; else exp_err = 1'b1;
            exp_wr.push_back('{1'b1, waddr, 16'h0, cyc + 1});
        end
        if (ra) begin
            if (c > 0) c--; else exp_err = 1'b1;
            exp_rd.push_back('{1'b0, raddr, rdat, cyc + 1});
        end
        exp_cnt = c;
        if (iss) begin
            it = mq.pop_front();
            it.stamp = cyc + 1;
            exp_iss.push_back(it);
            if (it.we) out_wr.push_back(it.addr); else out_rd.push_back(it.addr);
        end
        if (accepted) mq.push_back('{we, a, d, 0});
        exp_rdy = (mq.size() != DEPTH) || wfull;
        if (mq.size() == DEPTH) exp_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, acc);
    endtask

    // Asynchronous reset pulse between edges; pre-reset outstanding lists stay
    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; wr_ret_ack = 0; rd_ret_ack = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {wr_en, rd_en, wr_address, wr_data, rd_address, resp_wr_valid, resp_wr_addr,
                            resp_rd_valid, resp_rd_addr, resp_rd_data, out_cnt, err}, '0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        mq.delete(); exp_iss.delete(); exp_wr.delete(); exp_rd.delete(); wtab.delete();
        exp_cnt = 0; exp_err = 1'b0; exp_rdy = 1'b1;
        last_wa = '0; last_wd = '0; last_ra = '0;
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (mq.size() == 0 && out_wr.size() == 0 && out_rd.size() == 0 && exp_cnt == 0) break;
            step(0, 0, 16'h0, 16'h0, out_wr.size() > 0, out_rd.size() > 0, 16'($urandom), acc);
        end
    endtask

    initial begin
        int n, base;
        repeat (3) @(negedge clk);
        chk("init_outputs", {wr_en, rd_en, out_cnt, err, resp_wr_valid, resp_rd_valid}, '0);
        chk("init_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1'b1;

        // Underflow straight after reset
        step(0, 0, 16'h0, 16'h0, 0, 1, 16'h5555, acc);
        idle(1);
        chk("underflow_err", {31'd0, err}, 1);
        chk("underflow_cnt", out_cnt, 0);
        do_reset();

        // Write then read, then acks
        step(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, acc);
        step(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, acc);
        idle(3);
        step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0, acc);
        idle(3);
        drain();

        // Credit stall: 12 reads, no acks
        base = rd_pulses;
        n = 0;
        for (int k = 0; k < 40 && n < 12; k++) begin
            step(1, 0, 16'(16'h0100 + n), 16'h0, 0, 0, 16'h0, acc);
            if (acc) n++;
        end
        idle(3);
        chk("stall_cnt", out_cnt, 8);
        chk("stall_ready", {31'd0, in_ready}, 0);
        chk("stall_pulses", rd_pulses - base, 8);
        step(0, 0, 16'h0, 16'h0, 0, 1, 16'hA5A5, acc);
        idle(3);
        chk("stall_cnt_after_ack", out_cnt, 8);
        chk("stall_pulses_after_ack", rd_pulses - base, 9);
        drain();

        // Simultaneous acks from out_cnt = 3
        step(1, 1, 16'h0020, 16'h2222, 0, 0, 16'h0, acc);
        step(1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, acc);
        step(1, 0, 16'h0031, 16'h0, 0, 0, 16'h0, acc);
        idle(3);
        chk("simul_pre_cnt", out_cnt, 3);
        step(0, 0, 16'h0, 16'h0, 1, 1, 16'h1234, acc);
        idle(1);
        chk("simul_cnt", out_cnt, 1);
        drain();

        // Hazard pattern (stalls only when the table is built)
        step(1, 1, 16'h0040, 16'h4444, 0, 0, 16'h0, acc);
        idle(2);
        step(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, acc);
        step(1, 0, 16'h0041, 16'h0, 0, 0, 16'h0, acc);
        idle(4);
        step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0, acc);
        idle(4);
        drain();

        // Reset mid-operation with requests buffered and outstanding
        for (int k = 0; k < 6; k++) step(1, 0, 16'(16'h0200 + k), 16'h0, 0, 0, 16'h0, acc);
        do_reset();
        idle(3);
        drain();

        // Randomised traffic with a reset in the middle
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 16'($urandom_range(16'h40, 16'h47)),
                 16'($urandom), out_wr.size() > 0 && $urandom_range(0, 3) == 0,
                 out_rd.size() > 0 && $urandom_range(0, 3) == 0, 16'($urandom), acc);
        end
        drain();
        idle(3);
        chk("leftover_issue", exp_iss.size(), 0);
        chk("leftover_resp", exp_wr.size() + exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
